// File: rtl/mips_pkg.sv
// Shared MIPS control definitions: opcodes, multicycle states, datapath mux encodings.
// Pure declarations; no logic, no latency, no flow control.
// Consumed by the single-cycle and multicycle control units.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       retire;
    } ctrl_t;

    function automatic logic is_legal(input logic [5:0] op);
        return op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
    endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Moore output map for the multicycle controller: (state, mem_ready) -> control vector.
// Purely combinational, zero latency.
// mem_ready only gates the FETCH latch/PC enables and the MEMWR retire.
module mc_output_decode
    import mips_pkg::*;
(
    input  state_t st,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (st)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_src    = PCSRC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                // Speculative branch target into ALUOut.
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl.iord     = 1'b1;
                ctrl.mem_read = 1'b1;
            end
            S_MEMWB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.retire     = 1'b1;
            end
            S_MEMWR: begin
                ctrl.iord      = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.retire    = mem_ready;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.retire    = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_src        = PCSRC_ALUOUT;
                ctrl.retire        = 1'b1;
            end
            S_ADDIWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.retire    = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_write = 1'b1;
                ctrl.pc_src   = PCSRC_JUMP;
                ctrl.retire   = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM with illegal-opcode trap and retired-instruction counter.
// Outputs combinational from state; 2-5 cycles per instruction plus memory wait cycles.
// Holds in FETCH/MEMRD/MEMWR until mem_ready.
module multicycle_control
    import mips_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] Opcode,
    input  logic                Zero,
    input  logic                mem_ready,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                MemtoReg,
    output logic                RegDst,
    output logic                RegWrite,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          ALUOp,
    output logic [1:0]          PCSrc,
    output logic                retire,
    output logic                illegal,
    output logic [CNT_W-1:0]    instr_count,
    output logic [3:0]          state
);

    state_t     state_q;
    logic       is_store;
    ctrl_t      ctrl;
    logic [5:0] op;
    logic       unused_zero;

    assign op = 6'(Opcode);
    // Branch decision is made outside: PC enable = PCWrite | (PCWriteCond & Zero).
    assign unused_zero = Zero;

    mc_output_decode u_dec (
        .st        (state_q),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_FETCH;
            is_store    <= 1'b0;
            instr_count <= '0;
        end else begin
            if (ctrl.retire)
                instr_count <= instr_count + CNT_W'(1);
            case (state_q)
                S_FETCH:  if (mem_ready) state_q <= S_DECODE;
                S_DECODE: begin
                    // Opcode is only valid here, so lw/sw is remembered for MEMADR.
                    is_store <= (op == OP_SW);
                    case (op)
                        OP_RTYPE:     state_q <= S_EXEC;
                        OP_LW, OP_SW: state_q <= S_MEMADR;
                        OP_BEQ:       state_q <= S_BRANCH;
                        OP_ADDI:      state_q <= S_ADDIEX;
                        OP_J:         state_q <= S_JUMP;
                        default:      state_q <= S_FETCH;
                    endcase
                end
                S_MEMADR: state_q <= is_store ? S_MEMWR : S_MEMRD;
                S_MEMRD:  if (mem_ready) state_q <= S_MEMWB;
                S_MEMWR:  if (mem_ready) state_q <= S_FETCH;
                S_EXEC:   state_q <= S_ALUWB;
                S_ADDIEX: state_q <= S_ADDIWB;
                default:  state_q <= S_FETCH;
            endcase
        end
    end

    assign illegal     = (state_q == S_DECODE) && !is_legal(op);
    assign state       = state_q;
    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign IorD        = ctrl.iord;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign IRWrite     = ctrl.ir_write;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign RegDst      = ctrl.reg_dst;
    assign RegWrite    = ctrl.reg_write;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign ALUOp       = ctrl.alu_op;
    assign PCSrc       = ctrl.pc_src;
    assign retire      = ctrl.retire;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized instruction stream against a phase-list model of the multicycle controller.
module tb_multicycle_control;
    import mips_pkg::*;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [5:0]    Opcode = '0;
    logic          Zero = 1'b0;
    logic          mem_ready = 1'b1;
    logic          PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic          MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0]    ALUSrcB, ALUOp, PCSrc;
    logic          retire, illegal;
    logic [CW-1:0] instr_count;
    logic [3:0]    state;

    multicycle_control #(.OPCODE_W(6), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .Zero(Zero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSrc(PCSrc), .retire(retire), .illegal(illegal), .instr_count(instr_count),
        .state(state)
    );

    always #5 clk = ~clk;

    typedef enum int {P_FETCH, P_DECODE, P_DECODE_ILL, P_MEMADR, P_MEMRD, P_MEMWB,
                      P_MEMWR, P_EXEC, P_ALUWB, P_BRANCH, P_ADDIEX, P_ADDIWB, P_JUMP} ph_e;

    int checks = 0, errors = 0;
    int model_cnt = 0;
    int cycles = 0, n_retire = 0, n_regwr = 0, n_irw = 0, n_ill = 0;
    int zero_mode = 2;
    ph_e  pq[$];
    logic mq[$];

    logic [17:0] dut_ctrl;
    assign dut_ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                       RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc, retire, illegal};

    // Control vector each phase must show, straight from the state table.
    function automatic logic [17:0] exp_ctrl(input ph_e p, input logic mr);
        logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, ret, ill;
        logic [1:0] srcb, aluop, pcsrc;
        {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, ret, ill} = '0;
        srcb = 2'b00; aluop = 2'b00; pcsrc = 2'b00;
        case (p)
            P_FETCH:      begin mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; end
            P_DECODE:     srcb = 2'b11;
            P_DECODE_ILL: begin srcb = 2'b11; ill = 1; end
            P_MEMADR:     begin srca = 1; srcb = 2'b10; end
            P_MEMRD:      begin iord = 1; mrd = 1; end
            P_MEMWB:      begin m2r = 1; rw = 1; ret = 1; end
            P_MEMWR:      begin iord = 1; mwr = 1; ret = mr; end
            P_EXEC:       begin srca = 1; aluop = 2'b10; end
            P_ALUWB:      begin rdst = 1; rw = 1; ret = 1; end
            P_BRANCH:     begin srca = 1; aluop = 2'b01; pcwc = 1; pcsrc = 2'b01; ret = 1; end
            P_ADDIEX:     begin srca = 1; srcb = 2'b10; end
            P_ADDIWB:     begin rw = 1; ret = 1; end
            P_JUMP:       begin pcw = 1; pcsrc = 2'b10; ret = 1; end
            default:      ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, aluop, pcsrc, ret, ill};
    endfunction

    function automatic logic [3:0] exp_state(input ph_e p);
        case (p)
            P_FETCH:                return 4'(S_FETCH);
            P_DECODE, P_DECODE_ILL: return 4'(S_DECODE);
            P_MEMADR:               return 4'(S_MEMADR);
            P_MEMRD:                return 4'(S_MEMRD);
            P_MEMWB:                return 4'(S_MEMWB);
            P_MEMWR:                return 4'(S_MEMWR);
            P_EXEC:                 return 4'(S_EXEC);
            P_ALUWB:                return 4'(S_ALUWB);
            P_BRANCH:               return 4'(S_BRANCH);
            P_ADDIEX:               return 4'(S_ADDIEX);
            P_ADDIWB:               return 4'(S_ADDIWB);
            default:                return 4'(S_JUMP);
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at t=%0t", nm, got, expv, $time);
        end
    endtask

    // One clock cycle: entered and left at a falling edge.
    task automatic step(input ph_e p, input logic mr, input logic [5:0] op);
        logic [17:0] e;
        mem_ready = mr;
        Opcode    = op;
        Zero      = (zero_mode == 2) ? 1'($urandom) : 1'(zero_mode);
        e = exp_ctrl(p, mr);
        #2;
        chk("ctrl", 32'(dut_ctrl), 32'(e));
        chk("state", 32'(state), 32'(exp_state(p)));
        chk("instr_count", 32'(instr_count), 32'(model_cnt));
        if (retire)   n_retire++;
        if (RegWrite) n_regwr++;
        if (IRWrite)  n_irw++;
        if (illegal)  n_ill++;
        cycles++;
        @(posedge clk);
        if (e[1]) model_cnt = (model_cnt + 1) % (1 << CW);
        @(negedge clk);
    endtask

    task automatic do_reset(input logic mr);
        rst_n     = 1'b0;
        mem_ready = mr;
        model_cnt = 0;
        #2;
        chk("reset_ctrl", 32'(dut_ctrl), 32'(exp_ctrl(P_FETCH, mr)));
        chk("reset_state", 32'(state), 32'(S_FETCH));
        chk("reset_count", 32'(instr_count), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic void add(input ph_e p, input logic m);
        pq.push_back(p);
        mq.push_back(m);
    endfunction

    function automatic logic rnd();
        return 1'($urandom);
    endfunction

    task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input int abort_at);
        pq.delete();
        mq.delete();
        for (int i = 0; i < fw; i++) add(P_FETCH, 1'b0);
        add(P_FETCH, 1'b1);
        case (op)
            OP_RTYPE: begin add(P_DECODE, rnd()); add(P_EXEC, rnd()); add(P_ALUWB, rnd()); end
            OP_LW: begin
                add(P_DECODE, rnd()); add(P_MEMADR, rnd());
                for (int i = 0; i < mw; i++) add(P_MEMRD, 1'b0);
                add(P_MEMRD, 1'b1); add(P_MEMWB, rnd());
            end
            OP_SW: begin
                add(P_DECODE, rnd()); add(P_MEMADR, rnd());
                for (int i = 0; i < mw; i++) add(P_MEMWR, 1'b0);
                add(P_MEMWR, 1'b1);
            end
            OP_BEQ:  begin add(P_DECODE, rnd()); add(P_BRANCH, rnd()); end
            OP_ADDI: begin add(P_DECODE, rnd()); add(P_ADDIEX, rnd()); add(P_ADDIWB, rnd()); end
            OP_J:    begin add(P_DECODE, rnd()); add(P_JUMP, rnd()); end
            default: add(P_DECODE_ILL, rnd());
        endcase
        for (int i = 0; i < pq.size(); i++) begin
            if (i == abort_at) begin
                do_reset(rnd());
                return;
            end
            step(pq[i], mq[i], (pq[i] == P_DECODE || pq[i] == P_DECODE_ILL) ? op : 6'($urandom));
        end
    endtask

    initial begin
        logic [5:0] ops[6];
        logic [5:0] op;
        int saved;
        ops = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};

        @(negedge clk);
        do_reset(1'b1);

        // Abort a load while it waits in MEMRD, then run it cleanly.
        run_instr(OP_LW, 0, 2, 3);
        chk("abort_count", 32'(instr_count), 32'd0);
        cycles = 0; n_retire = 0;
        run_instr(OP_LW, 0, 0, -1);
        chk("lw_cycles", 32'(cycles), 32'd5);
        chk("lw_retires", 32'(n_retire), 32'd1);
        chk("lw_count", 32'(instr_count), 32'd1);

        cycles = 0; n_retire = 0; n_regwr = 0;
        run_instr(OP_RTYPE, 0, 0, -1);
        run_instr(OP_SW, 0, 0, -1);
        run_instr(OP_ADDI, 0, 0, -1);
        run_instr(OP_J, 0, 0, -1);
        chk("seq_cycles", 32'(cycles), 32'd15);
        chk("seq_retires", 32'(n_retire), 32'd4);
        chk("seq_regwrite", 32'(n_regwr), 32'd2);
        chk("seq_count", 32'(instr_count), 32'd5);

        zero_mode = 1; cycles = 0;
        run_instr(OP_BEQ, 0, 0, -1);
        chk("beq_z1_cycles", 32'(cycles), 32'd3);
        zero_mode = 0; cycles = 0;
        run_instr(OP_BEQ, 0, 0, -1);
        chk("beq_z0_cycles", 32'(cycles), 32'd3);
        zero_mode = 2;

        cycles = 0; n_irw = 0;
        run_instr(OP_LW, 3, 2, -1);
        chk("lw_wait_cycles", 32'(cycles), 32'd10);
        chk("lw_wait_irwrite", 32'(n_irw), 32'd1);

        cycles = 0; n_ill = 0; n_retire = 0;
        run_instr(6'b111111, 0, 0, -1);
        chk("ill_cycles", 32'(cycles), 32'd2);
        chk("ill_pulses", 32'(n_ill), 32'd1);
        chk("ill_retires", 32'(n_retire), 32'd0);
        chk("ill_count", 32'(instr_count), 32'd8);

        do_reset(1'b1);
        for (int i = 0; i < 15; i++) run_instr(OP_J, 0, 0, -1);
        chk("wrap_pre", 32'(instr_count), 32'd15);
        run_instr(OP_J, 0, 0, -1);
        chk("wrap_post", 32'(instr_count), 32'd0);

        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 6) == 6) begin
                do op = 6'($urandom); while (op inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J});
            end else begin
                op = ops[$urandom_range(0, 5)];
            end
            run_instr(op, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                      ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0,
                      ($urandom_range(0, 24) == 0) ? $urandom_range(0, 3) : -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle MIPS control unit. It replaces the single-cycle opcode decoder with a Moore state machine that steps each instruction through the FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK phases. It adds `addi`, `j`, memory wait-state handling, illegal-opcode trapping and a retired-instruction counter. It sits between the instruction register and a datapath that shares one memory, one ALU and the ALUOut/MDR latches.

## Interface
Parameters:
- `OPCODE_W`, 6: opcode field width.
- `CNT_W`, 32: retired-instruction counter width.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `Opcode`  in  OPCODE_W: IR[31:26]. Sampled only in DECODE.
- `Zero`  in  1: ALU zero flag. Used only in BRANCH.
- `mem_ready`  in  1: memory has completed the current read or write.
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `IRWrite`, `MemtoReg`, `RegDst`, `RegWrite`, `ALUSrcA`  out  1 each: datapath controls.
- `ALUSrcB`  out  2: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `ALUOp`  out  2: 00 = add, 01 = subtract, 10 = decode from funct.
- `PCSrc`  out  2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `retire`  out  1: one-cycle pulse on an instruction's final state.
- `illegal`  out  1: one-cycle pulse when an unsupported opcode is decoded.
- `instr_count`  out  CNT_W: number of retired instructions.
- `state`  out  4: current state, for debug.

## Operation
- States:
  - FETCH: MemRead=1, ALUSrcB=01, ALUOp=00, PCSrc=00. IRWrite and PCWrite equal mem_ready. Stays in FETCH while !mem_ready.
  - DECODE: ALUSrcB=11, ALUOp=00 (computes the branch target). Next state by opcode:
    - 000000 -> EXEC
    - 100011 / 101011 -> MEMADR
    - 000100 -> BRANCH
    - 001000 -> ADDIEX
    - 000010 -> JUMP
    - any other opcode -> FETCH, with `illegal`=1.
  - MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next is MEMRD for lw, MEMWR for sw.
  - MEMRD: IorD=1, MemRead=1. Waits for mem_ready, then -> MEMWB.
  - MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, retire -> FETCH.
  - MEMWR: IorD=1, MemWrite=1. Waits for mem_ready; on mem_ready, retire -> FETCH.
  - EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> ALUWB.
  - ALUWB: RegDst=1, RegWrite=1, retire -> FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSrc=01, retire -> FETCH.
  - ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> ADDIWB.
  - ADDIWB: RegDst=0, RegWrite=1, retire -> FETCH.
  - JUMP: PCWrite=1, PCSrc=10, retire -> FETCH.
- Every output not listed for a state is 0 in that state.
- `retire` is 1 in the final state only. In MEMWR it is 1 only when mem_ready=1.
- `instr_count` increments by 1 on every retire and wraps modulo 2^CNT_W. Illegal opcodes are not counted.
- The PC is gated externally as PCWrite | (PCWriteCond & Zero). The block does not AND with Zero internally.

## Timing
- Async reset: state=FETCH and instr_count=0 immediately. Outputs then show FETCH values: MemRead=1, ALUSrcB=01, IRWrite = PCWrite = mem_ready, all others 0.
- Reset release: the first FETCH is taken at the first rising edge after rst_n goes high.
- Cycles per instruction with mem_ready held at 1: R-type 4, lw 5, sw 4, beq 3, addi 4, j 3, illegal 2.
- Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle. All outputs stay stable during the wait.
- A reset asserted mid-instruction aborts the instruction. No retire, no count and no write enable are produced, and the block restarts in FETCH.
- At wrap, instr_count goes from all-ones to 0 together with that cycle's retire pulse.
- All control outputs are combinational from state, plus mem_ready in FETCH and MEMWR.

## Structure
- Shared package `mips_pkg` holds:
  - opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J;
  - the 4-bit state enum;
  - ALUOp, ALUSrcB and PCSrc encodings.
- The single-cycle control unit also imports the opcode and ALUOp constants from `mips_pkg`.
- One sub-module, `mc_output_decode`: a purely combinational map from (state, mem_ready) to the control vector. The top level keeps the state register, next-state logic and the counter.

## Test plan
- Reset mid-MEMRD, then release with Opcode=100011 and mem_ready=1 -> state=FETCH; instr_count=0; lw completes 5 cycles later with one retire; instr_count=1.
- Sequence R-type, sw, addi, j with mem_ready=1 -> 4 + 4 + 4 + 3 = 15 cycles; exactly 4 retire pulses; RegWrite high only in ALUWB and ADDIWB.
- beq with Zero=1, then beq with Zero=0 -> PCWriteCond=1 and PCSrc=01 in BRANCH for both; each takes 3 cycles.
- lw with mem_ready low for 3 cycles in FETCH and 2 cycles in MEMRD -> 10 cycles total; IRWrite high only in the FETCH cycle where mem_ready=1.
- Opcode=111111 -> `illegal` pulses in DECODE; next state is FETCH; instr_count unchanged; no write enable asserted.
- CNT_W=4 with 16 j instructions -> instr_count goes 15 -> 0 on the 16th retire.
